// File: rtl/wbck_if.sv
// Write-back bus between the execution units (ALU, LSU) and the write-back unit,
// plus the registered regfile write port driven by the write-back unit.
interface wbck_if #(
  parameter int XLEN          = 32,
  parameter int REG_IDX_WIDTH = 5
);
  logic                     alu_wb_valid_i;
  logic                     alu_wb_ready_o;
  logic [REG_IDX_WIDTH-1:0] alu_wb_idx_i;
  logic [XLEN-1:0]          alu_wb_data_i;

  logic                     lsu_wb_valid_i;
  logic                     lsu_wb_ready_o;
  logic [REG_IDX_WIDTH-1:0] lsu_wb_idx_i;
  logic [XLEN-1:0]          lsu_wb_data_i;

  logic                     rd_en_o;
  logic [REG_IDX_WIDTH-1:0] rd_idx_o;
  logic [XLEN-1:0]          rd_wdata_o;

  // Write-back unit side
  modport slave (
    input  alu_wb_valid_i, alu_wb_idx_i, alu_wb_data_i,
    output alu_wb_ready_o,
    input  lsu_wb_valid_i, lsu_wb_idx_i, lsu_wb_data_i,
    output lsu_wb_ready_o,
    output rd_en_o, rd_idx_o, rd_wdata_o
  );

  // Execution units / regfile side
  modport master (
    output alu_wb_valid_i, alu_wb_idx_i, alu_wb_data_i,
    input  alu_wb_ready_o,
    output lsu_wb_valid_i, lsu_wb_idx_i, lsu_wb_data_i,
    input  lsu_wb_ready_o,
    input  rd_en_o, rd_idx_o, rd_wdata_o
  );
endinterface

// File: rtl/wbck.sv
// Write-back unit: arbitrates ALU and LSU results onto the single regfile write
// port (LSU first, ALU gets one cycle of priority after STARVE_MAX refusals) and
// registers the winner for one cycle.
// Optional feature: define WBCK_SCOREBOARD_EN to build the per-register busy
// scoreboard; without it busy is tied low and the dispatch inputs are ignored.
module wbck #(
  parameter int STARVE_MAX    = 4,
  parameter int REG_NUM       = 32,
  parameter int XLEN          = 32,
  parameter int REG_IDX_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  wbck_if.slave                    wb,
  input  logic                     disp_en_i,
  input  logic [REG_IDX_WIDTH-1:0] disp_rd_idx_i,
  output logic [REG_NUM-1:0]       busy_o
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       alu_prio;
  logic       alu_acc;
  logic       lsu_acc;

  // Ready generation: LSU wins unless the ALU has been starved long enough;
  // neither ready looks at its own source's valid.
  always_comb begin
    alu_prio          = (starve_cnt == STARVE_LIM);
    wb.lsu_wb_ready_o = ~alu_prio;
    wb.alu_wb_ready_o = alu_prio | ~wb.lsu_wb_valid_i;
    alu_acc           = wb.alu_wb_valid_i & wb.alu_wb_ready_o;
    lsu_acc           = wb.lsu_wb_valid_i & wb.lsu_wb_ready_o;
  end

  // Count consecutive refused ALU cycles, saturating at the priority threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (!wb.alu_wb_valid_i || alu_acc) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Register the accepted result; writes to x0 are consumed without enabling
  // the regfile, and index/data hold when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.rd_en_o    <= 1'b0;
      wb.rd_idx_o   <= '0;
      wb.rd_wdata_o <= '0;
    end else if (lsu_acc) begin
      wb.rd_en_o    <= (wb.lsu_wb_idx_i != '0);
      wb.rd_idx_o   <= wb.lsu_wb_idx_i;
      wb.rd_wdata_o <= wb.lsu_wb_data_i;
    end else if (alu_acc) begin
      wb.rd_en_o    <= (wb.alu_wb_idx_i != '0);
      wb.rd_idx_o   <= wb.alu_wb_idx_i;
      wb.rd_wdata_o <= wb.alu_wb_data_i;
    end else begin
      wb.rd_en_o    <= 1'b0;
    end
  end

`ifdef WBCK_SCOREBOARD_EN
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] set_mask;
  logic [REG_NUM-1:0] clr_mask;

  // Decode the dispatch (set) and the actual regfile write (clear) into masks.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (disp_en_i && (disp_rd_idx_i != '0)) begin
      set_mask[disp_rd_idx_i] = 1'b1;
    end
    if (wb.rd_en_o) begin
      clr_mask[wb.rd_idx_o] = 1'b1;
    end
  end

  // Busy bits: a same-cycle set overrides the clear, and x0 is never busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= ((busy_q & ~clr_mask) | set_mask) & {{(REG_NUM-1){1'b1}}, 1'b0};
    end
  end

  assign busy_o = busy_q;
`else
  logic unused_disp;

  assign unused_disp = ^{disp_en_i, disp_rd_idx_i};
  assign busy_o      = '0;
`endif

endmodule

// File: doc/wbck.md
# wbck

Write-back unit between the execution units and the general register file. It arbitrates ALU and LSU results onto the single regfile write port, registers the winner for one cycle and drives `rd_en_o`/`rd_idx_o`/`rd_wdata_o` into the regfile. When the scoreboard is compiled in, it also keeps a per-register busy scoreboard that decode uses to stall RAW/WAW hazards.

## Interface
Parameters:
- `STARVE_MAX`, default 4: number of consecutive cycles the ALU may be refused before it gets one-cycle priority over the LSU; range 1..15.
- `REG_NUM`, default 32: number of architectural registers, and the width of `busy_o`.

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `alu_wb_valid_i`  in  1  ALU result valid.
- `alu_wb_ready_o`  out  1  ALU result accepted this cycle when high together with valid.
- `alu_wb_idx_i`  in  `REG_IDX_WIDTH`  ALU destination index.
- `alu_wb_data_i`  in  `XLEN`  ALU result.
- `lsu_wb_valid_i`  in  1  load result valid.
- `lsu_wb_ready_o`  out  1  load result accepted this cycle when high together with valid.
- `lsu_wb_idx_i`  in  `REG_IDX_WIDTH`  load destination index.
- `lsu_wb_data_i`  in  `XLEN`  load data.
- `disp_en_i`  in  1  decode dispatches an instruction that writes `disp_rd_idx_i`.
- `disp_rd_idx_i`  in  `REG_IDX_WIDTH`  destination index being dispatched.
- `rd_en_o`  out  1  regfile write enable (registered).
- `rd_idx_o`  out  `REG_IDX_WIDTH`  regfile write index (registered).
- `rd_wdata_o`  out  `XLEN`  regfile write data (registered).
- `busy_o`  out  `REG_NUM`  bit i is high while register i has an outstanding write.

## Operation
- Handshake: a transfer occurs when valid and ready are both high at a rising edge. A source holds valid, idx and data stable until it is accepted. Neither ready depends on that source's own valid.
- Arbitration:
  - Default priority is LSU. `lsu_wb_ready_o` = ~`alu_prio`. `alu_wb_ready_o` = `alu_prio` | ~`lsu_wb_valid_i`.
  - `alu_prio` is set when the starve counter equals `STARVE_MAX`.
- Starve counter, 4 bits:
  - Increments each cycle in which `alu_wb_valid_i` is high and the ALU is not accepted.
  - Clears when the ALU is accepted or `alu_wb_valid_i` is low.
  - Saturates at `STARVE_MAX`.
- Output stage:
  - On acceptance, latch idx and data.
  - `rd_en_o` <= 1 if idx != 0, else 0. A write to x0 is consumed but never written.
  - With no acceptance, `rd_en_o` <= 0; `rd_idx_o` and `rd_wdata_o` hold their values.
- Scoreboard (`WBCK_SCOREBOARD_EN` only), one bit per register:
  - Set: `disp_en_i` with `disp_rd_idx_i` != 0.
  - Clear: the edge at which the regfile actually writes, i.e. the edge ending a cycle with `rd_en_o` high, for index `rd_idx_o`.
  - Set and clear of the same index in the same cycle: set wins.
  - Bit 0 is constantly 0.
- Decode must not dispatch to a busy register, so one bit per register suffices. This block does not check for that.

## Timing
- Reset values:
  - `rd_en_o`=0, `rd_idx_o`=0, `rd_wdata_o`=0.
  - `busy_o`=0 and starve counter=0.
  - After reset: `alu_wb_ready_o`=1, `lsu_wb_ready_o`=1.
- Latency:
  - Accepted at edge E: `rd_en_o` is high for the cycle after E, and the regfile writes at edge E+1.
  - The busy bit drops at edge E+1, so decode reads fresh data the cycle busy is low. No bypass is required.
- Throughput: one write per cycle. Back-to-back acceptances give consecutive `rd_en_o` cycles.
- Reset mid-operation: all state clears asynchronously. An in-flight result is lost and is not written.

## Configuration
- `WBCK_SCOREBOARD_EN` defined: scoreboard as described above.
- Not defined:
  - No scoreboard flops are built.
  - `busy_o` is tied to 0.
  - `disp_en_i` and `disp_rd_idx_i` are ignored.
  - Arbitration and the output stage are unchanged.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle while `rd_en_o`=1 -> outputs go to 0 immediately, with no write on the following edges.
- Single ALU write: ALU valid, idx=5, data=0xDEADBEEF -> accepted; next cycle `rd_en_o`=1, `rd_idx_o`=5, `rd_wdata_o`=0xDEADBEEF; following cycle `rd_en_o`=0.
- Contention: both valid continuously, `STARVE_MAX`=4 -> LSU accepted 4 cycles in a row, then ALU accepted on the 5th cycle with `lsu_wb_ready_o`=0 that cycle; the pattern repeats.
- x0 write: LSU valid, idx=0, data=0x1234 -> accepted, `lsu_wb_ready_o`=1, `rd_en_o` stays 0, `busy_o`[0]=0.
- Scoreboard (macro on): dispatch idx=7 -> `busy_o`[7]=1 next cycle; ALU writes idx=7 -> `busy_o`[7] clears one cycle after the `rd_en_o` pulse. Dispatch idx=7 in the same cycle as that clear -> `busy_o`[7] remains 1.
- Macro off: dispatch idx=7 -> `busy_o`=0 throughout, and the ALU write of idx=7 still appears on `rd_*` with one-cycle latency.
